// File: rtl/mts_sysref_gate_ctrl.sv
// -----------------------------------------------------------------------------
// mts_sysref_gate_ctrl
//
// Gates the PL-synchronised SYSREF towards the RFDC for multi-tile sync. When
// software arms it, the block first checks that SYSREF is stable: NUM_QUAL
// consecutive periods must match the first measured period. It then forwards
// exactly num_pulses whole SYSREF pulses and closes the gate again, so SYSREF is
// off during normal operation.
//
// Ports
//   pl_clk        fabric clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   sysref_in     SYSREF already synchronised to pl_clk
//   arm           single-cycle start request (ignored when num_pulses == 0)
//   abort         single-cycle abort request, has priority over arm
//   num_pulses    number of pulses to forward, sampled on an accepted arm
//   sysref_gated  registered gated SYSREF towards the RFDC (1 cycle latency)
//   busy          high while qualifying, waiting for the first edge or passing
//   done          high while in DONE
//   err           high while in ERROR
//   ref_period    reference period captured during qualification
//   pulse_cnt     pulses forwarded in the current run
// -----------------------------------------------------------------------------
module mts_sysref_gate_ctrl #(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned NUM_QUAL   = 4,
  parameter int unsigned PERIOD_TOL = 0,
  parameter int unsigned PASS_W     = 8
) (
  input  logic                pl_clk,
  input  logic                rst,
  input  logic                sysref_in,
  input  logic                arm,
  input  logic                abort,
  input  logic [PASS_W-1:0]   num_pulses,
  output logic                sysref_gated,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [PERIOD_W-1:0] ref_period,
  output logic [PASS_W-1:0]   pulse_cnt
);

  localparam int unsigned QUAL_W = (NUM_QUAL < 32'd2) ? 32'd1 : $clog2(NUM_QUAL + 32'd1);
  localparam logic [QUAL_W-1:0]   QUAL_LAST = QUAL_W'(NUM_QUAL - 32'd1);
  localparam logic [QUAL_W-1:0]   QUAL_ONE  = QUAL_W'(1'b1);
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1'b1);
  localparam logic [PASS_W-1:0]   PASS_ONE  = PASS_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_QUALIFY   = 3'd1,
    ST_WAIT_EDGE = 3'd2,
    ST_PASS      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  sysref_d_r;
  logic                  rise_s;
  logic                  fall_s;
  logic [PERIOD_W-1:0]   period_cnt_r;
  logic                  cnt_sat_s;
  logic [PERIOD_W-1:0]   diff_s;
  logic                  match_s;
  logic                  arm_ok_s;
  logic                  open_s;
  logic [QUAL_W-1:0]     qual_cnt_r;
  logic                  seen_first_r;
  logic [PASS_W-1:0]     num_lat_r;
  logic [PASS_W-1:0]     pulse_cnt_r;
  logic [PERIOD_W-1:0]   ref_period_r;
  logic                  sysref_gated_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  // datapath strobes decoded alongside the next state
  logic                  start_s;
  logic                  seen_set_s;
  logic                  cap_ref_s;
  logic                  qual_inc_s;
  logic                  pass_start_s;
  logic                  pulse_inc_s;

  assign rise_s    = sysref_in & ~sysref_d_r;
  assign fall_s    = ~sysref_in & sysref_d_r;
  assign cnt_sat_s = (period_cnt_r == {PERIOD_W{1'b1}});
  assign arm_ok_s  = arm & (num_pulses != {PASS_W{1'b0}});

  // Period match: absolute difference taken without wrap-around
  always_comb begin
    diff_s = {PERIOD_W{1'b0}};
    if (period_cnt_r >= ref_period_r) begin
      diff_s = period_cnt_r - ref_period_r;
    end else begin
      diff_s = ref_period_r - period_cnt_r;
    end
    match_s = (32'(diff_s) <= 32'(PERIOD_TOL));
  end

  // Gate opens on the matching first edge in WAIT_EDGE so that pulse is forwarded whole
  assign open_s = (state_r == ST_PASS) | ((state_r == ST_WAIT_EDGE) & rise_s & match_s);

  // Next-state and datapath strobe decode
  always_comb begin
    state_nxt_s  = state_r;
    start_s      = 1'b0;
    seen_set_s   = 1'b0;
    cap_ref_s    = 1'b0;
    qual_inc_s   = 1'b0;
    pass_start_s = 1'b0;
    pulse_inc_s  = 1'b0;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (arm_ok_s) begin
            state_nxt_s = ST_QUALIFY;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_QUALIFY: begin
          if (cnt_sat_s) begin
            state_nxt_s = ST_ERROR;
          end else if (rise_s & ~seen_first_r) begin
            // first edge only starts the period timer
            seen_set_s = 1'b1;
          end else if (rise_s) begin
            // the first measurement becomes the reference and always counts
            if ((qual_cnt_r == {QUAL_W{1'b0}}) | match_s) begin
              cap_ref_s  = (qual_cnt_r == {QUAL_W{1'b0}});
              qual_inc_s = 1'b1;
              if (qual_cnt_r == QUAL_LAST) begin
                state_nxt_s = ST_WAIT_EDGE;
              end else begin
                state_nxt_s = ST_QUALIFY;
              end
            end else begin
              state_nxt_s = ST_ERROR;
            end
          end else begin
            state_nxt_s = ST_QUALIFY;
          end
        end
        ST_WAIT_EDGE: begin
          if (cnt_sat_s) begin
            state_nxt_s = ST_ERROR;
          end else if (rise_s & match_s) begin
            state_nxt_s  = ST_PASS;
            pass_start_s = 1'b1;
          end else if (rise_s) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_WAIT_EDGE;
          end
        end
        ST_PASS: begin
          if (cnt_sat_s) begin
            state_nxt_s = ST_ERROR;
          end else if (rise_s & match_s) begin
            pulse_inc_s = 1'b1;
          end else if (rise_s) begin
            state_nxt_s = ST_ERROR;
          end else if (fall_s & (pulse_cnt_r == num_lat_r)) begin
            // the low cycle is not forwarded, so exactly N pulses leave the block
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_PASS;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Edge history, period timer, qualification and pulse bookkeeping, registered outputs
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      sysref_d_r     <= 1'b0;
      period_cnt_r   <= {PERIOD_W{1'b0}};
      qual_cnt_r     <= {QUAL_W{1'b0}};
      seen_first_r   <= 1'b0;
      num_lat_r      <= {PASS_W{1'b0}};
      pulse_cnt_r    <= {PASS_W{1'b0}};
      ref_period_r   <= {PERIOD_W{1'b0}};
      sysref_gated_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      sysref_d_r <= sysref_in;
      // saturating timer; reaching all-ones means SYSREF went missing
      if (start_s) begin
        period_cnt_r <= {PERIOD_W{1'b0}};
      end else if (rise_s) begin
        period_cnt_r <= CNT_ONE;
      end else if (!cnt_sat_s) begin
        period_cnt_r <= period_cnt_r + CNT_ONE;
      end else begin
        period_cnt_r <= period_cnt_r;
      end
      if (start_s) begin
        qual_cnt_r   <= {QUAL_W{1'b0}};
        seen_first_r <= 1'b0;
        num_lat_r    <= num_pulses;
        ref_period_r <= {PERIOD_W{1'b0}};
        pulse_cnt_r  <= {PASS_W{1'b0}};
      end else begin
        if (seen_set_s) begin
          seen_first_r <= 1'b1;
        end
        if (qual_inc_s) begin
          qual_cnt_r <= qual_cnt_r + QUAL_ONE;
        end
        if (cap_ref_s) begin
          ref_period_r <= period_cnt_r;
        end
        if (pass_start_s) begin
          pulse_cnt_r <= PASS_ONE;
        end else if (pulse_inc_s) begin
          pulse_cnt_r <= pulse_cnt_r + PASS_ONE;
        end
      end
      sysref_gated_r <= sysref_in & open_s & ~abort;
      busy_r <= (state_nxt_s == ST_QUALIFY) | (state_nxt_s == ST_WAIT_EDGE) |
                (state_nxt_s == ST_PASS);
      done_r <= (state_nxt_s == ST_DONE);
      err_r  <= (state_nxt_s == ST_ERROR);
    end
  end

  assign sysref_gated = sysref_gated_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign ref_period   = ref_period_r;
  assign pulse_cnt    = pulse_cnt_r;

endmodule

// File: tb/tb_mts_sysref_gate_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for mts_sysref_gate_ctrl. Two instances share all inputs:
// dut_a (PERIOD_W=8, PERIOD_TOL=0) and dut_b (PERIOD_W=8, PERIOD_TOL=1).
// SYSREF is a 16-cycle period with 4 high cycles unless stated otherwise.
// -----------------------------------------------------------------------------
module tb_mts_sysref_gate_ctrl;

  logic       pl_clk = 1'b0;
  logic       rst;
  logic       sysref_in;
  logic       arm;
  logic       abort;
  logic [7:0] num_pulses;

  logic       a_gated, a_busy, a_done, a_err;
  logic [7:0] a_ref, a_pcnt;
  logic       b_gated, b_busy, b_done, b_err;
  logic [7:0] b_ref, b_pcnt;

  int n_checks = 0;
  int n_fail   = 0;

  // output monitor state (written only by the monitor process)
  int   a_rises = 0, a_high = 0, a_lat = 0;
  int   b_rises = 0;
  logic a_gated_prev = 1'b0, b_gated_prev = 1'b0, sref_prev = 1'b0;

  int base_r, base_h, base_b;

  always #5 pl_clk = ~pl_clk;

  mts_sysref_gate_ctrl #(
    .PERIOD_W(8), .NUM_QUAL(4), .PERIOD_TOL(0), .PASS_W(8)
  ) dut_a (
    .pl_clk(pl_clk), .rst(rst), .sysref_in(sysref_in), .arm(arm), .abort(abort),
    .num_pulses(num_pulses), .sysref_gated(a_gated), .busy(a_busy), .done(a_done),
    .err(a_err), .ref_period(a_ref), .pulse_cnt(a_pcnt)
  );

  mts_sysref_gate_ctrl #(
    .PERIOD_W(8), .NUM_QUAL(4), .PERIOD_TOL(1), .PASS_W(8)
  ) dut_b (
    .pl_clk(pl_clk), .rst(rst), .sysref_in(sysref_in), .arm(arm), .abort(abort),
    .num_pulses(num_pulses), .sysref_gated(b_gated), .busy(b_busy), .done(b_done),
    .err(b_err), .ref_period(b_ref), .pulse_cnt(b_pcnt)
  );

  // Count forwarded pulses/high cycles; gated high must follow a high input one cycle earlier
  always @(negedge pl_clk) begin
    a_rises      <= a_rises + ((a_gated & ~a_gated_prev) ? 32'd1 : 32'd0);
    a_high       <= a_high + (a_gated ? 32'd1 : 32'd0);
    a_lat        <= a_lat + ((a_gated & ~sref_prev) ? 32'd1 : 32'd0);
    b_rises      <= b_rises + ((b_gated & ~b_gated_prev) ? 32'd1 : 32'd0);
    a_gated_prev <= a_gated;
    b_gated_prev <= b_gated;
    sref_prev    <= sysref_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_cycle(input logic sref, input logic arm_v, input logic abort_v);
    sysref_in = sref;
    arm       = arm_v;
    abort     = abort_v;
    @(posedge pl_clk);
    #1;
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send_period(input int len, input int high, input int skip);
    for (int i = skip; i < len; i++) begin
      do_cycle((i < high) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_n(input int n);
    for (int k = 0; k < n; k++) begin
      send_period(32'd16, 32'd4, 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sysref_in  = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    num_pulses = 8'd0;
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("rst_gated", 32'(a_gated), 32'd0);
    check_eq("rst_flags", 32'({a_busy, a_done, a_err}), 32'd0);
    check_eq("rst_ref", 32'(a_ref), 32'd0);
    check_eq("rst_pcnt", 32'(a_pcnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 1'b0);

    // 1: three pulses after 5 qualifying rises
    base_r = a_rises; base_h = a_high; base_b = b_rises;
    num_pulses = 8'd3;
    do_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t1_busy_after_arm", 32'(a_busy), 32'd1);
    send_n(32'd10);
    check_eq("t1_done", 32'(a_done), 32'd1);
    check_eq("t1_busy", 32'(a_busy), 32'd0);
    check_eq("t1_err", 32'(a_err), 32'd0);
    check_eq("t1_ref", 32'(a_ref), 32'd16);
    check_eq("t1_pcnt", 32'(a_pcnt), 32'd3);
    check_eq("t1_rises", 32'(a_rises - base_r), 32'd3);
    check_eq("t1_high", 32'(a_high - base_h), 32'd12);
    check_eq("t1_b_rises", 32'(b_rises - base_b), 32'd3);

    // 2: periods 16,16,17 -> tol 0 errors, tol 1 qualifies
    base_r = a_rises; base_b = b_rises;
    do_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t2_done_clr", 32'(a_done), 32'd0);
    send_period(32'd16, 32'd4, 32'd0);
    send_period(32'd16, 32'd4, 32'd0);
    send_period(32'd17, 32'd4, 32'd0);
    check_eq("t2_err_before", 32'(a_err), 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0);
    check_eq("t2_err_a", 32'(a_err), 32'd1);
    check_eq("t2_busy_a", 32'(a_busy), 32'd0);
    check_eq("t2_err_b", 32'(b_err), 32'd0);
    check_eq("t2_busy_b", 32'(b_busy), 32'd1);
    send_period(32'd16, 32'd4, 32'd1);
    send_n(32'd5);
    check_eq("t2_rises_a", 32'(a_rises - base_r), 32'd0);
    check_eq("t2_ref_a", 32'(a_ref), 32'd16);
    check_eq("t2_done_b", 32'(b_done), 32'd1);
    check_eq("t2_pcnt_b", 32'(b_pcnt), 32'd3);
    check_eq("t2_rises_b", 32'(b_rises - base_b), 32'd3);

    // 3: SYSREF missing -> counter saturates at 255
    num_pulses = 8'd1;
    do_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("t3_err_pre", 32'(a_err), 32'd0);
    check_eq("t3_busy_pre", 32'(a_busy), 32'd1);
    do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("t3_err", 32'(a_err), 32'd1);
    check_eq("t3_busy", 32'(a_busy), 32'd0);

    // 4: abort one cycle after the second forwarded rise
    base_r = a_rises; base_h = a_high;
    num_pulses = 8'd4;
    do_cycle(1'b0, 1'b1, 1'b0);
    send_n(32'd6);
    do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1);
    check_eq("t4_gated", 32'(a_gated), 32'd0);
    check_eq("t4_flags", 32'({a_busy, a_done, a_err}), 32'd0);
    check_eq("t4_pcnt", 32'(a_pcnt), 32'd2);
    check_eq("t4_ref", 32'(a_ref), 32'd16);
    send_period(32'd16, 32'd4, 32'd2);
    check_eq("t4_rises", 32'(a_rises - base_r), 32'd2);
    check_eq("t4_high", 32'(a_high - base_h), 32'd5);

    // 5: arm with zero pulses ignored; reset mid-PASS; then a full run
    num_pulses = 8'd0;
    do_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t5_ign_busy", 32'(a_busy), 32'd0);
    check_eq("t5_ign_pcnt", 32'(a_pcnt), 32'd2);
    num_pulses = 8'd3;
    do_cycle(1'b0, 1'b1, 1'b0);
    send_n(32'd6);
    do_cycle(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    do_cycle(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check_eq("t5_rst_gated", 32'(a_gated), 32'd0);
    check_eq("t5_rst_flags", 32'({a_busy, a_done, a_err}), 32'd0);
    check_eq("t5_rst_ref", 32'(a_ref), 32'd0);
    check_eq("t5_rst_pcnt", 32'(a_pcnt), 32'd0);
    for (int i = 0; i < 14; i++) do_cycle(1'b0, 1'b0, 1'b0);
    base_r = a_rises;
    num_pulses = 8'd2;
    do_cycle(1'b0, 1'b1, 1'b0);
    send_n(32'd8);
    check_eq("t5_done", 32'(a_done), 32'd1);
    check_eq("t5_pcnt", 32'(a_pcnt), 32'd2);
    check_eq("t5_rises", 32'(a_rises - base_r), 32'd2);

    // 6: re-arm from DONE with one pulse, then arm+abort together
    base_r = a_rises; base_h = a_high;
    num_pulses = 8'd1;
    do_cycle(1'b0, 1'b1, 1'b0);
    check_eq("t6_done_clr", 32'(a_done), 32'd0);
    check_eq("t6_busy", 32'(a_busy), 32'd1);
    send_n(32'd7);
    check_eq("t6_done", 32'(a_done), 32'd1);
    check_eq("t6_pcnt", 32'(a_pcnt), 32'd1);
    check_eq("t6_rises", 32'(a_rises - base_r), 32'd1);
    check_eq("t6_high", 32'(a_high - base_h), 32'd4);
    do_cycle(1'b0, 1'b1, 1'b1);
    check_eq("t6_abort_flags", 32'({a_busy, a_done, a_err}), 32'd0);
    do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("t6_abort_idle", 32'({a_busy, a_done, a_err}), 32'd0);

    check_eq("latency", 32'(a_lat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mts_sysref_gate_ctrl.md
Name: mts_sysref_gate_ctrl

Overview:
Sequences delivery of the PL-synchronised SYSREF to the RFDC for multi-tile sync. On arm, it qualifies the SYSREF stream by checking that a number of consecutive periods are stable. It then opens a gate for exactly N whole SYSREF pulses and closes again, so SYSREF is off during normal operation. Sits in the pl_clk domain between the PL SYSREF synchroniser output and the RFDC user_sysref_adc input, and is controlled from a software register block.

Parameters:
PERIOD_W, 16, width of period counter and ref_period; counter saturating at 2^PERIOD_W-1 is the SYSREF-missing timeout.
NUM_QUAL, 4, number of consecutive matching periods required to qualify (NUM_QUAL+1 rising edges).
PERIOD_TOL, 0, allowed absolute difference (in cycles) between a measured period and ref_period.
PASS_W, 8, width of num_pulses and pulse_cnt.

Ports:
pl_clk  in  1  fabric clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
sysref_in  in  1  SYSREF already synchronised to pl_clk
arm  in  1  single-cycle start request
abort  in  1  single-cycle abort request; priority over arm
num_pulses  in  PASS_W  pulses to forward, sampled on accepted arm
sysref_gated  out  1  registered gated SYSREF to RFDC
busy  out  1  high in QUALIFY, WAIT_EDGE, PASS
done  out  1  level, high in DONE
err  out  1  level, high in ERROR
ref_period  out  PERIOD_W  reference period captured during qualification
pulse_cnt  out  PASS_W  pulses forwarded in the current run

Behaviour:
- Reset: state IDLE; sysref_gated, busy, done, err = 0; ref_period, pulse_cnt, qual count, period counter = 0; sysref_d = 0.
- Edge detect: sysref_d <= sysref_in. rise = sysref_in & ~sysref_d. fall = ~sysref_in & sysref_d.
- Period counter: cleared to 1 on rise, otherwise increments, saturating. Measured period P = counter value at a rise, i.e. the number of cycles between consecutive rises.
- Counter and qual count restart on entry to QUALIFY. Saturation of the counter in QUALIFY, WAIT_EDGE or PASS -> ERROR.
- Match: |P - ref_period| <= PERIOD_TOL, computed unsigned without wrap.
- IDLE: arm with num_pulses != 0 -> QUALIFY; latch num_pulses; clear ref_period and pulse_cnt. arm with num_pulses == 0 is ignored.
- QUALIFY:
  - First rise starts timing and takes no measurement.
  - Second rise: ref_period <= P; qual count = 1.
  - Each later rise: on match, qual count++; on mismatch -> ERROR.
  - When qual count reaches NUM_QUAL (on that rise) -> WAIT_EDGE.
- WAIT_EDGE: the next rise must match (mismatch -> ERROR); on it -> PASS with pulse_cnt = 1.
- Gate, combinational: open = (state==PASS) | (state==WAIT_EDGE & rise & match).
- Output: sysref_gated <= sysref_in & open & ~abort. Latency is exactly 1 cycle; whole pulses only.
- PASS:
  - Each rise: mismatch -> ERROR; otherwise pulse_cnt++.
  - fall with pulse_cnt == latched N -> DONE. The cycle with sysref_in low is not forwarded, so exactly N pulses appear.
- ERROR from PASS: gate closes immediately; a truncated final pulse is permitted.
- DONE / ERROR: outputs hold (ref_period, pulse_cnt retained). arm with num_pulses != 0 -> QUALIFY (clears err/done next cycle).
- abort in any state: -> IDLE next cycle; sysref_gated = 0 from the next cycle; ref_period and pulse_cnt retained. abort and arm in the same cycle: abort wins.
- rst mid-operation: immediate return to reset values on the next edge; no partial pulse persists beyond 1 cycle.
- done/err/busy are registered state decodes, valid the cycle after the transition.

Test Plan:
1. sysref period 16, high 4 cycles; NUM_QUAL=4, num_pulses=3; arm -> 5 rises qualify, 6th rise opens the gate. Expect exactly three 4-cycle pulses on sysref_gated, each delayed 1 cycle from sysref_in. Then done=1, busy=0, ref_period=16, pulse_cnt=3, and no further output.
2. Periods 16,16,17 during QUALIFY with PERIOD_TOL=0 -> err=1 the cycle after the 17-period rise; sysref_gated never high. Repeat with PERIOD_TOL=1 -> qualifies normally.
3. PERIOD_W=8, sysref_in held 0 after arm -> err=1 after the counter saturates at 255; busy falls with it.
4. num_pulses=4; abort one cycle after the 2nd forwarded rise -> sysref_gated=0 from the next cycle; state IDLE; busy=done=err=0; pulse_cnt=2.
5. arm with num_pulses=0 in IDLE -> no state change. Then rst asserted mid-PASS -> all outputs 0 next cycle; subsequent valid arm runs a full sequence.
6. From DONE, arm again with num_pulses=1 -> err/done clear. Requalification runs, exactly one pulse is forwarded, then done=1. Same-cycle arm+abort in DONE -> IDLE.
